// File: rtl/trdb_trigger_unit_if.sv
// Signal bundle between the trigger configuration/retire source and the trigger unit.
// The master drives config and the retire stream; the slave (trigger unit) returns pulses and status.
interface trdb_trigger_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             trig_enable_i;
    logic             trig_clear_i;
    logic             trig_rearm_i;
    logic [XLEN-1:0]  trig_on_addr_i;
    logic [XLEN-1:0]  trig_off_addr_i;
    logic [CNT_W-1:0] trig_on_count_i;
    logic             iretire_i;
    logic [XLEN-1:0]  iaddr_i;
    logic             trace_req_deactivate_i;
    logic             trigger_trace_on_o;
    logic             trigger_trace_off_o;
    logic [1:0]       trig_state_o;
    logic [CNT_W-1:0] trig_hit_count_o;

    modport master (
        output trig_enable_i, trig_clear_i, trig_rearm_i, trig_on_addr_i, trig_off_addr_i,
               trig_on_count_i, iretire_i, iaddr_i, trace_req_deactivate_i,
        input  trigger_trace_on_o, trigger_trace_off_o, trig_state_o, trig_hit_count_o
    );

    modport slave (
        input  trig_enable_i, trig_clear_i, trig_rearm_i, trig_on_addr_i, trig_off_addr_i,
               trig_on_count_i, iretire_i, iaddr_i, trace_req_deactivate_i,
        output trigger_trace_on_o, trigger_trace_off_o, trig_state_o, trig_hit_count_o
    );
endinterface

// File: rtl/trdb_trigger_unit.sv
// Trace trigger FSM: counts start-address hits, then emits one-cycle trace on/off pulses.
// Every output is registered so events in cycle N show up in cycle N+1.
module trdb_trigger_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    trdb_trigger_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRACING  = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_on, r_off, w_on_nxt, w_off_nxt;

    logic             w_on_hit, w_off_hit, w_fire;
    logic [CNT_W:0]   w_inc, w_thr;

    assign w_on_hit  = bus.iretire_i && (bus.iaddr_i == bus.trig_on_addr_i);
    assign w_off_hit = bus.iretire_i && (bus.iaddr_i == bus.trig_off_addr_i);

    // One extra bit so the saturating increment and the threshold compare never wrap.
    assign w_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_thr  = (bus.trig_on_count_i == '0) ? {{CNT_W{1'b0}}, 1'b1}
                                                : {1'b0, bus.trig_on_count_i};
    assign w_fire = w_inc >= w_thr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= DISARMED;
            r_cnt   <= '0;
            r_on    <= 1'b0;
            r_off   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_on    <= w_on_nxt;
            r_off   <= w_off_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_on_nxt    = 1'b0;
        w_off_nxt   = 1'b0;
        if (!bus.trig_enable_i) begin
            // Disarming mid-trace must still close the filter.
            w_state_nxt = DISARMED;
            w_cnt_nxt   = '0;
            w_off_nxt   = (r_state == TRACING);
        end else begin
            unique case (r_state)
                DISARMED: begin
                    w_state_nxt = ARMED;
                    w_cnt_nxt   = '0;
                end
                ARMED: begin
                    if (w_on_hit) begin
                        if (w_fire) begin
                            w_on_nxt    = 1'b1;
                            w_state_nxt = TRACING;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_inc[CNT_W] ? r_cnt : w_inc[CNT_W-1:0];
                        end
                    end
                end
                TRACING: begin
                    if (w_off_hit || bus.trace_req_deactivate_i) begin
                        w_off_nxt   = 1'b1;
                        w_state_nxt = bus.trig_rearm_i ? ARMED : DONE;
                        w_cnt_nxt   = '0;
                    end
                end
                DONE: begin
                    if (bus.trig_clear_i) w_state_nxt = DISARMED;
                end
                default: w_state_nxt = DISARMED;
            endcase
        end
    end

    assign bus.trigger_trace_on_o  = r_on;
    assign bus.trigger_trace_off_o = r_off;
    assign bus.trig_state_o        = r_state;
    assign bus.trig_hit_count_o    = r_cnt;
endmodule

// File: tb/tb_trdb_trigger_unit.sv
// Directed bench for trdb_trigger_unit: one-shot, count threshold, rearm, disable, equal addresses, async reset.
module tb_trdb_trigger_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    trdb_trigger_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    trdb_trigger_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic on, input logic off,
                           input logic [1:0] st, input logic [CNT_W-1:0] cnt);
        chk({tag, ".on"},  32'(bus.trigger_trace_on_o),  32'(on));
        chk({tag, ".off"}, 32'(bus.trigger_trace_off_o), 32'(off));
        chk({tag, ".st"},  32'(bus.trig_state_o),        32'(st));
        chk({tag, ".cnt"}, 32'(bus.trig_hit_count_o),    32'(cnt));
    endtask

    task automatic retire(input logic [XLEN-1:0] a);
        bus.iretire_i = 1'b1;
        bus.iaddr_i   = a;
        tick();
        bus.iretire_i = 1'b0;
    endtask

    initial begin
        rst_i                      = 1'b1;
        bus.trig_enable_i          = 1'b0;
        bus.trig_clear_i           = 1'b0;
        bus.trig_rearm_i           = 1'b0;
        bus.trig_on_addr_i         = 32'h100;
        bus.trig_off_addr_i        = 32'h200;
        bus.trig_on_count_i        = 16'd1;
        bus.iretire_i              = 1'b0;
        bus.iaddr_i                = '0;
        bus.trace_req_deactivate_i = 1'b0;
        tick();
        tick();
        chk_out("reset", 0, 0, 2'd0, 0);

        // basic one-shot
        rst_i = 1'b0;
        bus.trig_enable_i = 1'b1;
        tick();
        chk_out("arm", 0, 0, 2'd1, 0);
        tick();
        retire(32'h200);
        chk_out("off_in_armed", 0, 0, 2'd1, 0);
        retire(32'h100);
        chk_out("oneshot_on", 1, 0, 2'd2, 0);
        tick();
        chk_out("on_one_cycle", 0, 0, 2'd2, 0);
        retire(32'h100);
        chk_out("on_in_tracing", 0, 0, 2'd2, 0);
        retire(32'h200);
        chk_out("oneshot_off", 0, 1, 2'd3, 0);
        retire(32'h100);
        chk_out("done_quiet", 0, 0, 2'd3, 0);
        bus.trig_clear_i = 1'b1;
        tick();
        bus.trig_clear_i = 1'b0;
        chk_out("clear", 0, 0, 2'd0, 0);
        tick();
        chk_out("rearm_after_clear", 0, 0, 2'd1, 0);

        // count threshold of 3, non-consecutive hits
        bus.trig_on_count_i = 16'd3;
        retire(32'h100);
        chk_out("cnt1", 0, 0, 2'd1, 1);
        tick();
        retire(32'h100);
        chk_out("cnt2", 0, 0, 2'd1, 2);
        retire(32'h104);
        chk_out("cnt_nomatch", 0, 0, 2'd1, 2);
        retire(32'h100);
        chk_out("cnt3_fire", 1, 0, 2'd2, 0);

        // rearm via filter deactivate
        bus.trig_rearm_i = 1'b1;
        bus.trace_req_deactivate_i = 1'b1;
        tick();
        bus.trace_req_deactivate_i = 1'b0;
        chk_out("deact_off", 0, 1, 2'd1, 0);
        bus.trig_on_count_i = 16'd0;
        retire(32'h100);
        chk_out("count0_fire", 1, 0, 2'd2, 0);

        // disable during TRACING, then during ARMED
        bus.trig_enable_i = 1'b0;
        tick();
        chk_out("dis_tracing", 0, 1, 2'd0, 0);
        bus.trig_enable_i = 1'b1;
        tick();
        chk_out("reenable", 0, 0, 2'd1, 0);
        bus.trig_on_count_i = 16'd3;
        retire(32'h100);
        chk_out("armed_hit", 0, 0, 2'd1, 1);
        bus.trig_enable_i = 1'b0;
        tick();
        chk_out("dis_armed", 0, 0, 2'd0, 0);
        bus.trig_enable_i = 1'b1;
        tick();
        bus.trace_req_deactivate_i = 1'b1;
        tick();
        bus.trace_req_deactivate_i = 1'b0;
        chk_out("deact_in_armed", 0, 0, 2'd1, 0);

        // equal on/off addresses with rearm
        bus.trig_on_count_i = 16'd1;
        bus.trig_on_addr_i  = 32'h300;
        bus.trig_off_addr_i = 32'h300;
        retire(32'h300);
        chk_out("eq_on", 1, 0, 2'd2, 0);
        retire(32'h300);
        chk_out("eq_off", 0, 1, 2'd1, 0);
        tick();
        chk_out("eq_no_refire", 0, 0, 2'd1, 0);

        // async reset between edges while TRACING, on pulse still high
        retire(32'h300);
        chk_out("pre_reset", 1, 0, 2'd2, 0);
        #2 rst_i = 1'b1;
        #1 chk_out("async_reset", 0, 0, 2'd0, 0);
        #1 rst_i = 1'b0;
        tick();
        chk_out("post_reset_arm", 0, 0, 2'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
